// File: rtl/ysyx_25020047_lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states
// and the address-alignment check used when a request is accepted.
package ysyx_25020047_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Half accesses need an even address, word accesses a multiple of four.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_H:    return lsb[0];
            SZ_W:    return (lsb != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Byte-lane steering for a 32-bit word port: replicates store data into the
// target lanes with matching strobes, and extracts/extends load data.
// Purely combinational so it can be shared with a future cache.
module ysyx_25020047_lsu_align
    import ysyx_25020047_lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lsb,
    input  logic        i_wen,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_lsb, 3'b000} +: 8];
    assign w_half = i_rdata[{i_lsb[1], 4'b0000} +: 16];

    // Store path: replicate the datum across the word and enable only its lanes.
    always_comb begin
        o_wdata = 32'd0;
        o_wstrb = 4'd0;
        if (i_wen) begin
            case (i_size)
                SZ_B: begin
                    o_wdata = {4{i_wdata[7:0]}};
                    o_wstrb = 4'b0001 << i_lsb;
                end
                SZ_H: begin
                    o_wdata = {2{i_wdata[15:0]}};
                    o_wstrb = 4'b0011 << i_lsb;
                end
                SZ_W: begin
                    o_wdata = i_wdata;
                    o_wstrb = 4'hF;
                end
                default: ;
            endcase
        end
    end

    // Load path: pick the addressed lane(s) and sign- or zero-extend.
    always_comb begin
        o_rdata = 32'd0;
        if (!i_wen) begin
            case (i_size)
                SZ_B:    o_rdata = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
                SZ_H:    o_rdata = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
                SZ_W:    o_rdata = i_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: accepts one EXU memory request at a time and turns it into
// a single word-aligned valid/ready transaction, returning extended load data.
// Optional watchdog: define YSYX_25020047_LSU_TIMEOUT_EN to abort a request
// that sits in REQ or WAIT for TIMEOUT_CYCLES cycles (reported as an error).
module ysyx_25020047_lsu
    import ysyx_25020047_lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    lsu_state_t          r_state;
    lsu_state_t          w_next;
    logic                r_wen;
    logic                r_unsigned;
    logic                r_err;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_bad;
    logic                w_capture;
    logic                w_tmo_err;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_st_wdata;
    logic [DATA_W/8-1:0] w_st_wstrb;
    logic [DATA_W-1:0]   w_ld_rdata;

    // Reserved size or misaligned address never reaches the memory port.
    assign w_bad = (req_size == 2'd3) || lsu_misaligned(req_size, req_addr[1:0]);

`ifdef YSYX_25020047_LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] r_cnt;

    // Cycles spent in the current REQ/WAIT visit; any state change restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (w_next != r_state)
            r_cnt <= '0;
        else if (r_state == REQ || r_state == WAIT)
            r_cnt <= r_cnt + 1'b1;
    end

    // Fires on the TIMEOUT_CYCLES-th cycle of a visit.
    assign w_timeout = (r_state == REQ || r_state == WAIT) &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = |TIMEOUT_CYCLES;
    assign w_timeout    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and handshake outputs; a same-cycle rvalid on the request
    // handshake skips WAIT, and a real response always beats the watchdog.
    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_tmo_err  = 1'b0;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    w_next = w_bad ? RESP : REQ;
            end
            REQ: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    if (mem_rvalid) begin
                        w_next    = RESP;
                        w_capture = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end else if (w_timeout) begin
                    w_next    = RESP;
                    w_tmo_err = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    w_next    = RESP;
                    w_capture = 1'b1;
                end else if (w_timeout) begin
                    w_next    = RESP;
                    w_tmo_err = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture on acceptance, raw read word capture on rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen      <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_wen      <= req_wen;
                r_unsigned <= req_unsigned;
                r_err      <= w_bad;
                r_size     <= req_size;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_rdata    <= '0;
            end
            if (w_capture)
                r_rdata <= mem_rdata;
            if (w_tmo_err)
                r_err <= 1'b1;
        end
    end

    ysyx_25020047_lsu_align u_align (
        .i_size     (r_size),
        .i_lsb      (r_addr[1:0]),
        .i_wen      (r_wen),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata    (r_rdata),
        .o_wdata    (w_st_wdata),
        .o_wstrb    (w_st_wstrb),
        .o_rdata    (w_ld_rdata)
    );

    // Memory-side fields are only driven while the request is presented.
    assign mem_addr   = mem_valid ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wen    = mem_valid & r_wen;
    assign mem_wdata  = mem_valid ? w_st_wdata : '0;
    assign mem_wstrb  = mem_valid ? w_st_wstrb : '0;

    // Response fields are zero outside the response pulse; errors carry no data.
    assign resp_err   = resp_valid & r_err;
    assign resp_rdata = (resp_valid && !r_err) ? w_ld_rdata : '0;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Randomised bench for the LSU: a transaction-level model predicts, cycle by
// cycle, what every output must be from the request and the memory timing.
module tb_ysyx_25020047_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_25020047_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    // Expected outputs for the current cycle
    logic        chk_en = 1'b0;
    logic        e_req_ready, e_mem_valid, e_mem_wen, e_resp_valid, e_resp_err, e_chk_wdata;
    logic [31:0] e_mem_addr, e_mem_wdata, e_resp_rdata;
    logic [3:0]  e_mem_wstrb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic f_bad(input logic [1:0] sz, input logic [1:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0);
    endfunction

    function automatic logic [3:0] f_strb(input logic [1:0] sz, input logic [1:0] a, input logic wen);
        if (!wen) return 4'd0;
        if (sz == 2'd0) return 4'(1 << a);
        if (sz == 2'd1) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] f_load(input logic [1:0] sz, input logic [1:0] a,
                                          input logic [31:0] raw, input logic uns);
        int          bits;
        logic [31:0] mask, v;
        if (sz == 2'd2) return raw;
        bits = (sz == 2'd0) ? 8 : 16;
        mask = (32'd1 << bits) - 32'd1;
        v    = (raw >> (int'(a) * 8)) & mask;
        if (!uns && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(e_req_ready));
            chk("mem_valid", 32'(mem_valid), 32'(e_mem_valid));
            if (e_mem_valid) begin
                chk("mem_addr", mem_addr, e_mem_addr);
                chk("mem_wen", 32'(mem_wen), 32'(e_mem_wen));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(e_mem_wstrb));
                if (e_chk_wdata) chk("mem_wdata", mem_wdata, e_mem_wdata);
            end
            chk("resp_valid", 32'(resp_valid), 32'(e_resp_valid));
            chk("resp_err", 32'(resp_err), 32'(e_resp_err));
            chk("resp_rdata", resp_rdata, e_resp_rdata);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_quiet(input logic rdy);
        e_req_ready  = rdy;
        e_mem_valid  = 1'b0;
        e_mem_wen    = 1'b0;
        e_mem_addr   = 32'd0;
        e_mem_wstrb  = 4'd0;
        e_mem_wdata  = 32'd0;
        e_chk_wdata  = 1'b0;
        e_resp_valid = 1'b0;
        e_resp_err   = 1'b0;
        e_resp_rdata = 32'd0;
    endtask

    task automatic idle_cycle();
        exp_quiet(1'b1);
        req_valid  = 1'b0;
        mem_ready  = 1'($urandom);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        next_cycle();
    endtask

    // One request: d1 = cycles mem_ready stays low, d2 = cycles from the
    // handshake to rvalid (0 = same cycle). Called at a cycle where the LSU is idle.
    task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns, input int d1, input int d2,
                          input logic [31:0] rdw);
        logic bad;
        bad = f_bad(sz, addr[1:0]);
        // acceptance cycle; a stray rvalid here must be ignored
        exp_quiet(1'b1);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_addr     = addr;
        req_wdata    = wd;
        req_size     = sz;
        req_unsigned = uns;
        mem_ready    = 1'($urandom);
        mem_rvalid   = 1'($urandom);
        mem_rdata    = $urandom;
        next_cycle();
        mem_rvalid = 1'b0;
        if (!bad) begin
            for (int i = 0; i <= d1; i++) begin
                exp_quiet(1'b0);
                e_mem_valid = 1'b1;
                e_mem_addr  = {addr[31:2], 2'b00};
                e_mem_wen   = wen;
                e_mem_wstrb = f_strb(sz, addr[1:0], wen);
                e_mem_wdata = f_wdata(sz, wd);
                e_chk_wdata = wen;
                // request inputs wander while busy; the registered copy must hold
                req_valid   = 1'($urandom);
                req_wen     = 1'($urandom);
                req_addr    = $urandom;
                req_wdata   = $urandom;
                req_size    = 2'($urandom);
                mem_ready   = (i == d1);
                mem_rvalid  = (i == d1) && (d2 == 0);
                mem_rdata   = mem_rvalid ? rdw : $urandom;
                next_cycle();
            end
            for (int j = 1; j <= d2; j++) begin
                exp_quiet(1'b0);
                req_valid  = 1'($urandom);
                mem_ready  = 1'($urandom);
                mem_rvalid = (j == d2);
                mem_rdata  = mem_rvalid ? rdw : $urandom;
                next_cycle();
            end
        end
        // response cycle
        exp_quiet(1'b0);
        e_resp_valid = 1'b1;
        e_resp_err   = bad;
        e_resp_rdata = (bad || wen) ? 32'd0 : f_load(sz, addr[1:0], rdw, uns);
        req_valid    = 1'($urandom);
        mem_ready    = 1'($urandom);
        mem_rvalid   = 1'b0;
        mem_rdata    = $urandom;
        next_cycle();
        exp_quiet(1'b1);
        req_valid  = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_wen      = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        mem_ready    = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'd0;
        exp_quiet(1'b1);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);

        // literal pins for the model
        chk("pin_sb_strb", 32'(f_strb(2'd0, 2'd3, 1'b1)), 32'h8);
        chk("pin_sb_wdata", f_wdata(2'd0, 32'h123456AB), 32'hABABABAB);
        chk("pin_lh", f_load(2'd1, 2'd2, 32'h8001FFFF, 1'b0), 32'hFFFF8001);
        chk("pin_lhu", f_load(2'd1, 2'd2, 32'h8001FFFF, 1'b1), 32'h00008001);
        chk("pin_lw_misalign", 32'(f_bad(2'd2, 2'd2)), 32'd1);
        chk("pin_lb", f_load(2'd0, 2'd1, 32'h0000_8000, 1'b0), 32'hFFFFFF80);

        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        idle_cycle();

        // directed cases
        do_txn(1'b1, 32'h80000003, 32'h123456AB, 2'd0, 1'b0, 0, 0, 32'd0);
        idle_cycle();
        do_txn(1'b0, 32'h80000002, 32'h0, 2'd1, 1'b0, 0, 3, 32'h8001FFFF);
        do_txn(1'b0, 32'h80000002, 32'h0, 2'd1, 1'b1, 0, 3, 32'h8001FFFF);
        do_txn(1'b0, 32'h80000006, 32'h0, 2'd2, 1'b0, 0, 0, 32'h0);
        do_txn(1'b1, 32'h80000104, 32'hCAFEF00D, 2'd2, 1'b0, 5, 1, 32'h0);
        do_txn(1'b0, 32'h80000201, 32'h0, 2'd3, 1'b0, 0, 0, 32'h0);
        do_txn(1'b1, 32'h80000202, 32'h0000BEEF, 2'd1, 1'b0, 2, 0, 32'h0);

        // asynchronous reset while waiting for read data
        exp_quiet(1'b1);
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_addr   = 32'h80000010;
        req_size   = 2'd2;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        next_cycle();
        exp_quiet(1'b0);
        e_mem_valid = 1'b1;
        e_mem_addr  = 32'h80000010;
        e_mem_wen   = 1'b0;
        e_mem_wstrb = 4'd0;
        req_valid   = 1'b0;
        mem_ready   = 1'b1;
        next_cycle();
        exp_quiet(1'b0);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        chk("arst_mem_valid", 32'(mem_valid), 32'd0);
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_resp_err", 32'(resp_err), 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        exp_quiet(1'b1);
        chk_en = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5A5A5A5A;
        next_cycle();
        mem_rvalid = 1'b1;
        next_cycle();
        mem_rvalid = 1'b0;
        next_cycle();
        idle_cycle();

        // randomised traffic
        for (int t = 0; t < 300; t++) begin
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_txn(1'($urandom), a, $urandom, sz, 1'($urandom),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        idle_cycle();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
